data_memory_ctrl: RTL and testbench

Parametrised, reset-initialised data memory for the NanoRisc datapath, replacing the fixed 8-bit × 16 data memory. It sits between the execute stage and the register-file write-back mux. After reset it runs an initialisation sweep that writes the boot constants. It then serves one read and/or one write per cycle on the rising clock edge, with write-first forwarding, a read-valid strobe and an out-of-range address flag.

---
 rtl/data_memory_ctrl.sv | 132 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Parametrised data memory for the NanoRisc datapath. After reset an
//   initialisation sweep writes the boot constants (or all zeros), one word
//   per clock. After the sweep the block serves one read and/or one write per
//   clock with write-first forwarding, a read-valid strobe and an
//   out-of-range address flag.
//
//   Handshake: a request is accepted on a rising edge when ready is high and
//   MemRead and/or MemWrite is high. There is no back-pressure once ready is
//   up. The results of an accepted request appear one cycle later:
//     - dataOut / dataValid for a read;
//     - addrError for any request whose address is outside the memory.
//
// Ports
//   clock      system clock, rising edge
//   resetn     asynchronous active-low reset
//   address    word address for the read and/or write
//   writeData  write data
//   MemRead    read request
//   MemWrite   write request
//   dataOut    registered read data, held until the next accepted read
//   dataValid  one-cycle pulse, dataOut updated on the preceding edge
//   ready      high once the init sweep has finished (state IDLE)
//   addrError  one-cycle pulse, an accepted request had address >= DEPTH
module data_memory_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int PRELOAD    = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic                  ready,
  output logic                  addrError
);

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  // One bit wider than the address so the sweep counter cannot wrap when
  // DEPTH fills the whole address space.
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_W     = (ADDR_WIDTH+1)'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     clr_addr_q, clr_addr_d;
  logic                    init_wr;
  logic                    rd_acc, wr_acc, in_range;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Boot constant for a given word; values wider than DATA_WIDTH truncate.
  function automatic logic [DATA_WIDTH-1:0] init_value(input logic [ADDR_WIDTH:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (PRELOAD != 0) begin
      if (a == (ADDR_WIDTH+1)'(0))      v = 32'd1;
      else if (a == (ADDR_WIDTH+1)'(1)) v = 32'd15;
      else if (a == (ADDR_WIDTH+1)'(2)) v = 32'd5;
    end
    return DATA_WIDTH'(v);
  endfunction

  assign in_range = {1'b0, address} < DEPTH_W;
  assign ready    = (state_q == IDLE);
  assign rd_acc   = ready && MemRead;
  assign wr_acc   = ready && MemWrite;

  // Next-state logic; the sweep counter only advances while in INIT.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    init_wr    = 1'b0;
    case (state_q)
      INIT: begin
        init_wr    = 1'b1;
        clr_addr_d = clr_addr_q + ONE_W;
        if (clr_addr_q == LAST_ADDR) state_d = IDLE;
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= INIT;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Storage carries no reset; the sweep defines its contents.
  always_ff @(posedge clock) begin
    if (init_wr) begin
      mem[clr_addr_q[ADDR_WIDTH-1:0]] <= init_value(clr_addr_q);
    end else if (wr_acc && in_range) begin
      mem[address] <= writeData;
    end
  end

  // Read port. A simultaneous write to the same word forwards writeData
  // (write-first); an out-of-range read returns zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dataOut   <= '0;
      dataValid <= 1'b0;
      addrError <= 1'b0;
    end else begin
      dataValid <= rd_acc;
      addrError <= (rd_acc || wr_acc) && !in_range;
      if (rd_acc) begin
        if (!in_range)   dataOut <= '0;
        else if (wr_acc) dataOut <= writeData;
        else             dataOut <= mem[address];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default parameters
  logic        resetn_a = 1'b0;
  logic [3:0]  address_a = '0;
  logic [7:0]  wdata_a = '0;
  logic        rd_a = 1'b0, wr_a = 1'b0;
  logic [7:0]  dout_a;
  logic        valid_a, ready_a, err_a;

  // Instance B: wide data, DEPTH smaller than the address space, no preload
  logic        resetn_b = 1'b0;
  logic [4:0]  address_b = '0;
  logic [15:0] wdata_b = '0;
  logic        rd_b = 1'b0, wr_b = 1'b0;
  logic [15:0] dout_b;
  logic        valid_b, ready_b, err_b;

  data_memory_ctrl u_dut_a (
    .clock(clock), .resetn(resetn_a), .address(address_a), .writeData(wdata_a),
    .MemRead(rd_a), .MemWrite(wr_a), .dataOut(dout_a), .dataValid(valid_a),
    .ready(ready_a), .addrError(err_a)
  );

  data_memory_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(24), .PRELOAD(0)) u_dut_b (
    .clock(clock), .resetn(resetn_b), .address(address_b), .writeData(wdata_b),
    .MemRead(rd_b), .MemWrite(wr_b), .dataOut(dout_b), .dataValid(valid_b),
    .ready(ready_b), .addrError(err_b)
  );

  // ---------------- scoreboard / reference model ----------------
  int errors = 0;
  int checks = 0;

  logic [7:0]  mem_a [16];
  logic [7:0]  exp_out_a = '0;
  logic [15:0] mem_b [24];
  logic [15:0] exp_out_b = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_init_a();
    for (int i = 0; i < 16; i++) mem_a[i] = 8'h00;
    mem_a[0] = 8'd1; mem_a[1] = 8'd15; mem_a[2] = 8'd5;
  endtask

  // ---------------- driver tasks ----------------
  // Drive one request, advance one edge, and compare against the model.
  task automatic step_a(input logic r, input logic w, input logic [3:0] a,
                        input logic [7:0] d, input string tag);
    rd_a = r; wr_a = w; address_a = a; wdata_a = d;
    @(posedge clock); #1;
    if (w) mem_a[a] = d;
    if (r) exp_out_a = mem_a[a];
    chk({tag, "_dout"},  32'(dout_a),  32'(exp_out_a));
    chk({tag, "_valid"}, 32'(valid_a), 32'(r));
    chk({tag, "_err"},   32'(err_a),   32'd0);
    chk({tag, "_ready"}, 32'(ready_a), 32'd1);
  endtask

  task automatic step_b(input logic r, input logic w, input logic [4:0] a,
                        input logic [15:0] d, input string tag);
    logic in;
    rd_b = r; wr_b = w; address_b = a; wdata_b = d;
    @(posedge clock); #1;
    in = (int'(a) < 24);
    if (w && in) mem_b[a] = d;
    if (r) exp_out_b = in ? mem_b[a] : 16'h0000;
    chk({tag, "_dout"},  32'(dout_b),  32'(exp_out_b));
    chk({tag, "_valid"}, 32'(valid_b), 32'(r));
    chk({tag, "_err"},   32'(err_b),   32'((r || w) && !in));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;

    // Reset state of A
    rd_a = 1'b1; address_a = 4'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_dout_a",  32'(dout_a),  32'd0);
    chk("rst_valid_a", 32'(valid_a), 32'd0);
    chk("rst_err_a",   32'(err_a),   32'd0);
    chk("rst_ready_a", 32'(ready_a), 32'd0);

    // Init sweep with a read held on address 0: ignored until ready
    resetn_a = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clock); #1;
      chk($sformatf("init_ready_a_e%0d", e), 32'(ready_a), 32'(e == 16));
      chk($sformatf("init_valid_a_e%0d", e), 32'(valid_a), 32'd0);
    end
    load_init_a();
    exp_out_a = '0;

    for (int i = 0; i < 4; i++) step_a(1'b1, 1'b0, 4'(i), 8'h00, $sformatf("boot%0d", i));

    // Write then read, then idle: dataValid pulses for one cycle only
    step_a(1'b0, 1'b1, 4'd7, 8'hA5, "wr7");
    step_a(1'b1, 1'b0, 4'd7, 8'h00, "rd7");
    step_a(1'b0, 1'b0, 4'd0, 8'h00, "idle7");

    // Same-cycle read+write (write-first)
    step_a(1'b1, 1'b1, 4'd4, 8'h3C, "rw4");
    step_a(1'b0, 1'b0, 4'd0, 8'h00, "idle4");
    step_a(1'b1, 1'b0, 4'd4, 8'h00, "rd4");

    // Random traffic
    for (int i = 0; i < 60; i++)
      step_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 8'($urandom), $sformatf("rnd_a%0d", i));

    // Asynchronous reset while a read result is showing
    step_a(1'b1, 1'b0, 4'd3, 8'h00, "pre_rst");
    resetn_a = 1'b0; #1;
    chk("async_valid_a", 32'(valid_a), 32'd0);
    chk("async_ready_a", 32'(ready_a), 32'd0);
    chk("async_dout_a",  32'(dout_a),  32'd0);

    // Mid-sweep reset: 5 edges of INIT, then reset again; writes ignored in INIT
    rd_a = 1'b0; wr_a = 1'b1; address_a = 4'd2; wdata_a = 8'hEE;
    resetn_a = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    resetn_a = 1'b0;
    @(posedge clock); #1;
    chk("midrst_ready_a", 32'(ready_a), 32'd0);
    resetn_a = 1'b1;
    n = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock); #1;
      if (ready_a) begin n = e; break; end
    end
    chk("midrst_len_a", 32'(n), 32'd16);
    wr_a = 1'b0;
    load_init_a();
    exp_out_a = '0;
    for (int i = 0; i < 16; i++) step_a(1'b1, 1'b0, 4'(i), 8'h00, $sformatf("rb_a%0d", i));

    // ---------------- instance B ----------------
    chk("rst_ready_b", 32'(ready_b), 32'd0);
    chk("rst_dout_b",  32'(dout_b),  32'd0);
    resetn_b = 1'b1;
    n = 0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clock); #1;
      chk($sformatf("init_valid_b_e%0d", e), 32'(valid_b), 32'd0);
      if (ready_b) begin n = e; break; end
    end
    chk("init_len_b", 32'(n), 32'd24);
    for (int i = 0; i < 24; i++) mem_b[i] = 16'h0000;
    exp_out_b = '0;

    for (int i = 0; i < 24; i++) step_b(1'b1, 1'b0, 5'(i), 16'h0, $sformatf("zero_b%0d", i));

    for (int i = 0; i < 60; i++)
      step_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 16'($urandom), $sformatf("rnd_b%0d", i));

    // Out-of-range write and read
    step_b(1'b0, 1'b1, 5'd27, 16'hFFFF, "oor_wr");
    step_b(1'b1, 1'b0, 5'd27, 16'h0, "oor_rd");
    step_b(1'b0, 1'b0, 5'd0, 16'h0, "oor_idle");
    for (int i = 0; i < 24; i++) step_b(1'b1, 1'b0, 5'(i), 16'h0, $sformatf("rb_b%0d", i));

    // Top-word round trip
    step_b(1'b0, 1'b1, 5'd23, 16'hBEEF, "beef_wr");
    step_b(1'b1, 1'b0, 5'd23, 16'h0, "beef_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
